// File: rtl/pc_predict_unit.sv
// Fetch-stage PC generation for a 5-stage Y86-64 pipeline: predicted-PC register,
// mispredict/ret correction select, and a circular return-address stack for ret prediction.
module pc_predict_unit #(
    parameter int             W         = 64,
    parameter int             RAS_DEPTH = 8,
    parameter logic [W-1:0]   RESET_PC  = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         F_stall,
    input  logic [3:0]                   f_icode,
    input  logic [W-1:0]                 f_valC,
    input  logic [W-1:0]                 f_valP,
    input  logic [3:0]                   M_icode,
    input  logic                         M_cnd,
    input  logic [W-1:0]                 M_valA,
    input  logic [3:0]                   W_icode,
    input  logic [W-1:0]                 W_valM,
    input  logic                         W_ret_pred,
    input  logic [W-1:0]                 W_predPC,
    output logic [W-1:0]                 f_pc,
    output logic [W-1:0]                 F_predPC,
    output logic                         f_ret_pred,
    output logic                         redirect,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;

    logic [W-1:0]  predpc_q, predpc_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  ras_mem [RAS_DEPTH];

    logic          w_fix, m_fix;
    logic [PW-1:0] ptr_eff;
    logic [CW-1:0] cnt_eff;
    logic [W-1:0]  ras_top;
    logic          is_call, is_ret, push_en;

    // W is older than M, so a ret correction outranks a jXX mispredict.
    always_comb begin
        w_fix    = (W_icode == I_RET) && (!W_ret_pred || (W_valM != W_predPC));
        m_fix    = (M_icode == I_JXX) && !M_cnd;
        redirect = w_fix || m_fix;
        if (w_fix)
            f_pc = W_valM;
        else if (m_fix)
            f_pc = M_valA;
        else
            f_pc = predpc_q;
    end

    // A redirect clears the speculative stack first; any call/ret fetched
    // this cycle then operates on the emptied stack.
    always_comb begin
        ptr_eff    = redirect ? '0 : ptr_q;
        cnt_eff    = redirect ? '0 : cnt_q;
        ras_top    = ras_mem[ptr_eff - PW'(1)];
        is_call    = (f_icode == I_CALL);
        is_ret     = (f_icode == I_RET);
        f_ret_pred = is_ret && (cnt_eff != '0);
        push_en    = !reset && !F_stall && is_call;

        ptr_d    = ptr_eff;
        cnt_d    = cnt_eff;
        predpc_d = f_valP;
        if (f_icode == I_JXX || is_call)
            predpc_d = f_valC;
        else if (f_ret_pred)
            predpc_d = ras_top;

        if (is_call) begin
            ptr_d = ptr_eff + PW'(1);
            cnt_d = (cnt_eff == CW'(RAS_DEPTH)) ? cnt_eff : cnt_eff + CW'(1);
        end else if (f_ret_pred) begin
            ptr_d = ptr_eff - PW'(1);
            cnt_d = cnt_eff - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            predpc_q <= RESET_PC;
            ptr_q    <= '0;
            cnt_q    <= '0;
        end else if (!F_stall) begin
            predpc_q <= predpc_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // When full, the write pointer lands on the oldest entry and overwrites it.
    generate
        for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
            always_ff @(posedge clk) begin
                if (push_en && (ptr_eff == PW'(gi)))
                    ras_mem[gi] <= f_valP;
            end
        end
    endgenerate

    assign F_predPC  = predpc_q;
    assign ras_count = cnt_q;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit: one task per scenario, inline checks, one summary line.
module tb_pc_predict_unit;

    localparam int W         = 64;
    localparam int RAS_DEPTH = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         F_stall;
    logic [3:0]   f_icode;
    logic [W-1:0] f_valC, f_valP;
    logic [3:0]   M_icode;
    logic         M_cnd;
    logic [W-1:0] M_valA;
    logic [3:0]   W_icode;
    logic [W-1:0] W_valM;
    logic         W_ret_pred;
    logic [W-1:0] W_predPC;
    logic [W-1:0] f_pc, F_predPC;
    logic         f_ret_pred, redirect;
    logic [3:0]   ras_count;

    int passed = 0;
    int total  = 0;

    pc_predict_unit #(.W(W), .RAS_DEPTH(RAS_DEPTH), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .F_stall(F_stall),
        .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
        .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM), .W_ret_pred(W_ret_pred), .W_predPC(W_predPC),
        .f_pc(f_pc), .F_predPC(F_predPC), .f_ret_pred(f_ret_pred),
        .redirect(redirect), .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neutral();
        F_stall = 0; f_icode = 0; f_valC = 0; f_valP = 0;
        M_icode = 0; M_cnd = 0; M_valA = 0;
        W_icode = 0; W_valM = 0; W_ret_pred = 0; W_predPC = 0;
    endtask

    task automatic test_reset();
        neutral();
        reset = 1;
        tick(); tick();
        total++; if (F_predPC !== 64'h0) $display("FAIL reset_predpc: got %h want 0", F_predPC); else passed++;
        total++; if (ras_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", ras_count); else passed++;
        reset = 0; f_valP = 64'h8;
        #1;
        total++; if (f_pc !== 64'h0) $display("FAIL reset_fpc: got %h want 0", f_pc); else passed++;
        total++; if (redirect !== 1'b0) $display("FAIL reset_redirect: got %b want 0", redirect); else passed++;
        tick();
        total++; if (F_predPC !== 64'h8) $display("FAIL reset_next: got %h want 8", F_predPC); else passed++;
        total++; if (ras_count !== 4'd0) $display("FAIL reset_count2: got %0d want 0", ras_count); else passed++;
        $display("txn reset: F_predPC=%h ras_count=%0d", F_predPC, ras_count);
    endtask

    task automatic test_call_ret();
        neutral();
        f_icode = 8; f_valC = 64'h100; f_valP = 64'h40;
        #1;
        total++; if (f_ret_pred !== 1'b0) $display("FAIL call_retpred: got %b want 0", f_ret_pred); else passed++;
        tick();
        total++; if (F_predPC !== 64'h100) $display("FAIL call_predpc: got %h want 100", F_predPC); else passed++;
        total++; if (ras_count !== 4'd1) $display("FAIL call_count: got %0d want 1", ras_count); else passed++;
        total++; if (f_pc !== 64'h100) $display("FAIL call_fpc: got %h want 100", f_pc); else passed++;
        f_icode = 9; f_valC = 0; f_valP = 64'h101;
        #1;
        total++; if (f_ret_pred !== 1'b1) $display("FAIL ret_retpred: got %b want 1", f_ret_pred); else passed++;
        tick();
        total++; if (F_predPC !== 64'h40) $display("FAIL ret_predpc: got %h want 40", F_predPC); else passed++;
        total++; if (ras_count !== 4'd0) $display("FAIL ret_count: got %0d want 0", ras_count); else passed++;
        f_icode = 0; f_valP = 64'h41;
        W_icode = 9; W_ret_pred = 1; W_valM = 64'h40; W_predPC = 64'h40;
        #1;
        total++; if (redirect !== 1'b0) $display("FAIL ret_ok_redirect: got %b want 0", redirect); else passed++;
        total++; if (f_pc !== 64'h40) $display("FAIL ret_ok_fpc: got %h want 40", f_pc); else passed++;
        tick();
        $display("txn call_ret: F_predPC=%h ras_count=%0d", F_predPC, ras_count);
    endtask

    task automatic test_ret_mispredict();
        neutral();
        f_icode = 8; f_valC = 64'h200; f_valP = 64'h50;
        tick();
        total++; if (ras_count !== 4'd1) $display("FAIL wfix_pre_count: got %0d want 1", ras_count); else passed++;
        f_icode = 0; f_valC = 0; f_valP = 64'h208;
        W_icode = 9; W_ret_pred = 1; W_valM = 64'h80; W_predPC = 64'h40;
        #1;
        total++; if (f_pc !== 64'h80) $display("FAIL wfix_fpc: got %h want 80", f_pc); else passed++;
        total++; if (redirect !== 1'b1) $display("FAIL wfix_redirect: got %b want 1", redirect); else passed++;
        tick();
        total++; if (ras_count !== 4'd0) $display("FAIL wfix_count: got %0d want 0", ras_count); else passed++;
        total++; if (F_predPC !== 64'h208) $display("FAIL wfix_predpc: got %h want 208", F_predPC); else passed++;
        // unpredicted ret always redirects even when the addresses happen to agree
        W_ret_pred = 0; W_valM = 64'h40; W_predPC = 64'h40;
        #1;
        total++; if (redirect !== 1'b1) $display("FAIL wfix_nopred: got %b want 1", redirect); else passed++;
        W_icode = 6; W_valM = 64'h99;
        #1;
        total++; if (redirect !== 1'b0) $display("FAIL wfix_notret: got %b want 0", redirect); else passed++;
        total++; if (f_pc !== 64'h208) $display("FAIL wfix_notret_fpc: got %h want 208", f_pc); else passed++;
        $display("txn ret_mispredict: f_pc=%h redirect=%b", f_pc, redirect);
    endtask

    task automatic test_jxx_mispredict();
        neutral();
        f_valP = 64'h209;
        M_icode = 7; M_cnd = 0; M_valA = 64'h58;
        #1;
        total++; if (f_pc !== 64'h58) $display("FAIL mfix_fpc: got %h want 58", f_pc); else passed++;
        total++; if (redirect !== 1'b1) $display("FAIL mfix_redirect: got %b want 1", redirect); else passed++;
        M_cnd = 1;
        #1;
        total++; if (redirect !== 1'b0) $display("FAIL mfix_taken: got %b want 0", redirect); else passed++;
        M_cnd = 0; W_icode = 9; W_ret_pred = 1; W_valM = 64'h90; W_predPC = 64'h40;
        #1;
        total++; if (f_pc !== 64'h90) $display("FAIL mfix_wprio: got %h want 90", f_pc); else passed++;
        // call fetched on the corrected path lands in a freshly cleared stack
        f_icode = 8; f_valC = 64'h300; f_valP = 64'h94;
        tick();
        total++; if (ras_count !== 4'd1) $display("FAIL redir_call_count: got %0d want 1", ras_count); else passed++;
        total++; if (F_predPC !== 64'h300) $display("FAIL redir_call_predpc: got %h want 300", F_predPC); else passed++;
        neutral();
        f_icode = 9; f_valP = 64'h301;
        #1;
        total++; if (f_ret_pred !== 1'b1) $display("FAIL redir_ret_pred: got %b want 1", f_ret_pred); else passed++;
        tick();
        total++; if (F_predPC !== 64'h94) $display("FAIL redir_ret_predpc: got %h want 94", F_predPC); else passed++;
        f_icode = 8; f_valC = 64'h340; f_valP = 64'h98;
        tick();
        f_icode = 9; f_valP = 64'h341; M_icode = 7; M_cnd = 0; M_valA = 64'h5c;
        #1;
        total++; if (f_ret_pred !== 1'b0) $display("FAIL redir_ret_empty: got %b want 0", f_ret_pred); else passed++;
        tick();
        total++; if (F_predPC !== 64'h341) $display("FAIL redir_ret_empty_predpc: got %h want 341", F_predPC); else passed++;
        total++; if (ras_count !== 4'd0) $display("FAIL redir_ret_empty_count: got %0d want 0", ras_count); else passed++;
        $display("txn jxx_mispredict: F_predPC=%h ras_count=%0d", F_predPC, ras_count);
    endtask

    task automatic test_overflow();
        logic [W-1:0] exp_pc;
        neutral();
        for (int i = 1; i <= RAS_DEPTH + 1; i++) begin
            f_icode = 8; f_valC = 64'h1000; f_valP = W'(i * 16);
            tick();
        end
        total++; if (ras_count !== 4'(RAS_DEPTH)) $display("FAIL ovf_count: got %0d want %0d", ras_count, RAS_DEPTH); else passed++;
        for (int k = 0; k < RAS_DEPTH; k++) begin
            f_icode = 9; f_valC = 0; f_valP = 64'h2000;
            exp_pc = W'((RAS_DEPTH + 1 - k) * 16);
            #1;
            total++; if (f_ret_pred !== 1'b1) $display("FAIL ovf_retpred%0d: got %b want 1", k, f_ret_pred); else passed++;
            tick();
            total++; if (F_predPC !== exp_pc) $display("FAIL ovf_pop%0d: got %h want %h", k, F_predPC, exp_pc); else passed++;
            $display("txn ovf_pop%0d: F_predPC=%h ras_count=%0d", k, F_predPC, ras_count);
        end
        f_valP = 64'h2008;
        #1;
        total++; if (f_ret_pred !== 1'b0) $display("FAIL ovf_lost: got %b want 0", f_ret_pred); else passed++;
        tick();
        total++; if (F_predPC !== 64'h2008) $display("FAIL ovf_lost_predpc: got %h want 2008", F_predPC); else passed++;
        total++; if (ras_count !== 4'd0) $display("FAIL ovf_end_count: got %0d want 0", ras_count); else passed++;
    endtask

    task automatic test_stall();
        neutral();
        f_icode = 8; f_valC = 64'h400; f_valP = 64'h60;
        tick();
        F_stall = 1; f_valC = 64'h500; f_valP = 64'h70;
        tick();
        total++; if (F_predPC !== 64'h400) $display("FAIL stall_predpc: got %h want 400", F_predPC); else passed++;
        total++; if (ras_count !== 4'd1) $display("FAIL stall_count: got %0d want 1", ras_count); else passed++;
        M_icode = 7; M_cnd = 0; M_valA = 64'h77;
        #1;
        total++; if (redirect !== 1'b1) $display("FAIL stall_redirect: got %b want 1", redirect); else passed++;
        tick();
        total++; if (ras_count !== 4'd1) $display("FAIL stall_redir_count: got %0d want 1", ras_count); else passed++;
        total++; if (F_predPC !== 64'h400) $display("FAIL stall_redir_predpc: got %h want 400", F_predPC); else passed++;
        reset = 1;
        tick();
        total++; if (F_predPC !== 64'h0) $display("FAIL stall_reset_predpc: got %h want 0", F_predPC); else passed++;
        total++; if (ras_count !== 4'd0) $display("FAIL stall_reset_count: got %0d want 0", ras_count); else passed++;
        reset = 0;
        neutral();
        $display("txn stall: F_predPC=%h ras_count=%0d", F_predPC, ras_count);
    endtask

    initial begin
        reset = 1;
        neutral();
        test_reset();
        test_call_ret();
        test_ret_mispredict();
        test_jxx_mispredict();
        test_overflow();
        test_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
